// File: rtl/instr_fetch_queue.sv
// Byte-serial instruction fetch: four acked byte beats form a word that is pushed into a DEPTH-entry queue toward IF/ID.
// Head visible combinationally; a new word starts only while the queue has room; redirect flushes everything.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        fetch_en,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ack,
   input  logic [7:0]  imem_rdata,
   output logic        if_valid,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   input  logic        id_ready,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        misalign
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic {IDLE, FETCH} state_t;

   state_t        state;
   logic [1:0]    beat;
   logic [31:0]   fpc;
   logic [23:0]   asm_q;
   logic [CW-1:0] count;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] wr_ptr;
   logic [31:0]   instr_mem [DEPTH];
   logic [31:0]   pc_mem [DEPTH];

   logic          ack_ok;
   logic          push;
   logic          pop;
   logic [CW-1:0] count_nxt;
   logic [31:0]   word;

   // A redirect cycle swallows any ack, push or pop so nothing stale survives the flush.
   assign imem_req  = (state == FETCH);
   assign imem_addr = fpc + {30'd0, beat};
   assign ack_ok    = imem_req && imem_ack && !redirect;
   assign push      = ack_ok && (beat == 2'd3);
   assign pop       = (count != '0) && id_ready && !redirect;
   assign count_nxt = count + CW'(push) - CW'(pop);
   assign word      = {imem_rdata, asm_q};
   assign if_valid  = (count != '0);
   assign if_instr  = instr_mem[rd_ptr];
   assign if_pc     = pc_mem[rd_ptr];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= IDLE;
         beat     <= 2'd0;
         fpc      <= RESET_PC;
         asm_q    <= '0;
         misalign <= 1'b0;
      end else begin
         misalign <= redirect && (redirect_pc[1:0] != 2'b00);
         if (redirect) begin
            state <= fetch_en ? FETCH : IDLE;
            beat  <= 2'd0;
            asm_q <= '0;
            fpc   <= {redirect_pc[31:2], 2'b00};
         end else begin
            case (state)
               IDLE: begin
                  if (fetch_en && (count < FULL))
                     state <= FETCH;
               end
               FETCH: begin
                  if (ack_ok) begin
                     if (beat == 2'd3) begin
                        fpc   <= fpc + 32'd4;
                        beat  <= 2'd0;
                        asm_q <= '0;
                        // Room is judged after this cycle's push/pop so the next word never overflows.
                        state <= (fetch_en && (count_nxt < FULL)) ? FETCH : IDLE;
                     end else begin
                        beat <= beat + 2'd1;
                        case (beat)
                           2'd0:    asm_q[7:0]   <= imem_rdata;
                           2'd1:    asm_q[15:8]  <= imem_rdata;
                           default: asm_q[23:16] <= imem_rdata;
                        endcase
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[AW'(i)] <= '0;
            pc_mem[AW'(i)]    <= '0;
         end
      end else if (redirect) begin
         count  <= '0;
         rd_ptr <= '0;
         wr_ptr <= '0;
      end else begin
         if (push) begin
            instr_mem[wr_ptr] <= word;
            pc_mem[wr_ptr]    <= fpc;
            wr_ptr            <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_nxt;
      end
   end
endmodule
